input_buffer: RTL and testbench
===============================

INPUT_BUFFER -- requirements
Module: input_buffer

Interface
REQ-001 Parameter: NUM_INPUTS, default 16, number of fixed-point samples per frame presented to the downstream neuron layer.
REQ-002 clock  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-004 in_data  in  signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]  serial fixed-point sample.
REQ-005 in_valid  in  1  in_data/in_last valid this cycle.
REQ-006 in_last  in  1  marks final sample of a frame.
REQ-007 in_ready  out  1  buffer can accept a sample this cycle.
REQ-008 inputs  out  signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] x NUM_INPUTS (unpacked)  parallel frame to downstream layer.
REQ-009 inputs_ready  out  1  one-cycle pulse: inputs holds a complete frame.
REQ-010 output_ready  in  1  downstream finished with the presented frame; buffer may be released.
REQ-011 frame_error  out  1  one-cycle pulse on framing violation.

Function
REQ-012 Sample accepted iff in_valid && in_ready on a rising edge; written to slot count, count then increments; in_data ignored otherwise.
REQ-013 FSM states FILLING, PRESENTING, HOLDING; FILLING -> PRESENTING on acceptance of sample NUM_INPUTS-1 (count == NUM_INPUTS-1).
REQ-014 PRESENTING lasts exactly one cycle with inputs_ready=1, then -> HOLDING; inputs_ready=0 in every other state.
REQ-015 Latency: acceptance of final sample in cycle N -> inputs_ready=1 and complete inputs in cycle N+1.
REQ-016 inputs SHALL remain stable from PRESENTING until the cycle after output_ready is sampled high in HOLDING.
REQ-017 HOLDING -> FILLING with count=0 on output_ready=1; output_ready in FILLING or PRESENTING is ignored.
REQ-018 in_ready=1 in FILLING, 0 in PRESENTING and HOLDING (single-buffer build).
REQ-019 in_last accepted with count < NUM_INPUTS-1: frame_error pulses next cycle, partial frame discarded, count=0, stay FILLING, no inputs_ready.
REQ-020 Final sample (count == NUM_INPUTS-1) accepted with in_last=0: frame still presented, frame_error pulses in the same cycle as inputs_ready.
REQ-021 count width $clog2(NUM_INPUTS), minimum 1; count never exceeds NUM_INPUTS-1 (no wrap past frame end).

Reset
REQ-022 reset=1: state FILLING, count=0, all inputs slots 0, inputs_ready=0, frame_error=0, in_ready=1 in the cycle after reset deasserts.
REQ-023 reset mid-frame or mid-HOLDING discards all buffered data; no inputs_ready is produced for the aborted frame.

Configuration
REQ-024 Macro INPUT_BUFFER_DOUBLE_BUFFER_EN defined: two banks (ping-pong); one bank presented/held while the other fills; in_ready=1 whenever the fill bank is not complete.
REQ-025 With macro: fill bank completes while other bank HOLDING -> in_ready=0, completed bank waits; on output_ready, banks swap and inputs_ready pulses the next cycle (release-to-present latency 1).
REQ-026 With macro: fill bank completes while no bank held -> present per REQ-015; with output_ready and final-sample acceptance in the same cycle, release and swap both take effect, inputs_ready next cycle.
REQ-027 Macro undefined: single bank, behaviour exactly REQ-012..REQ-021; no second bank storage.

Structure
REQ-028 INTEGER_WIDTH, FRACTION_WIDTH and the fixed-point sample typedef come from the shared package include file; no local redefinition.
REQ-029 FSM state enum local to module; one sub-module natural: input_bank (NUM_INPUTS-slot register file, write-enable + index), instantiated once or twice per REQ-024/027.

Verification
REQ-030 16 samples 1.0..16.0 streamed back-to-back, in_last on 16th -> inputs_ready one cycle after 16th accept, inputs[i]=i+1.0, frame_error=0.
REQ-031 in_last on 5th sample -> frame_error pulse, no inputs_ready; following clean 16-sample frame presented correctly.
REQ-032 16 samples with in_last never set -> inputs_ready and frame_error pulse together, data correct.
REQ-033 Single-buffer: after presentation, hold output_ready=0 for 20 cycles with in_valid=1 -> in_ready=0, inputs unchanged; output_ready=1 -> in_ready=1 next cycle.
REQ-034 Double-buffer: second frame streamed while first held -> in_ready=0 after 16th sample; output_ready=1 -> second frame inputs_ready next cycle.
REQ-035 reset asserted after 8 samples -> all outputs 0, next full frame presented with no residue.

Source files
------------

// File: rtl/input_buffer_pkg.sv
// input_buffer_pkg: fixed-point sample format shared by the input buffer and its banks
package input_buffer_pkg;
    localparam int INTEGER_WIDTH = 8;
    localparam int FRACTION_WIDTH = 8;
    typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] sample_t;
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/input_buffer_if.sv
// input_buffer_if: serial sample stream in, parallel frame out to the neuron layer
interface input_buffer_if
    import input_buffer_pkg::*;
#(
    parameter int NUM_INPUTS = 16
);
    sample_t in_data;
    logic in_valid;
    logic in_last;
    logic in_ready;
    sample_t inputs [NUM_INPUTS];
    logic inputs_ready;
    logic output_ready;
    logic frame_error;
    modport slave (
        input in_data, in_valid, in_last, output_ready,
        output in_ready, inputs, inputs_ready, frame_error
    );
    modport master (
        output in_data, in_valid, in_last, output_ready,
        input in_ready, inputs, inputs_ready, frame_error
    );
endinterface

// File: rtl/input_buffer_input_bank.sv
// input_bank: NUM_INPUTS-slot sample register file with a single indexed write port
module input_bank
    import input_buffer_pkg::*;
#(
    parameter int NUM_INPUTS = 16,
    parameter int CW = count_width(NUM_INPUTS)
) (
    input logic clock,
    input logic reset,
    input logic we,
    input logic [CW-1:0] idx,
    input sample_t din,
    output sample_t q [NUM_INPUTS]
);
    always_ff @(posedge clock) begin
        if (reset) q <= '{default: '0};
        else if (we) q[idx] <= din;
    end
endmodule

// File: rtl/input_buffer.sv
// input_buffer: collects serial samples into a NUM_INPUTS frame and holds it for the downstream layer.
// Define INPUT_BUFFER_DOUBLE_BUFFER_EN for ping-pong banks so the next frame fills while one is held.
module input_buffer
    import input_buffer_pkg::*;
#(
    parameter int NUM_INPUTS = 16
) (
    input logic clock,
    input logic reset,
    input_buffer_if.slave bus
);
    localparam int CW = count_width(NUM_INPUTS);
    typedef enum logic [1:0] {FILLING, PRESENTING, HOLDING} state_t;
    state_t state;
    logic [CW-1:0] count;
    logic present;
    logic error;
    logic accept;
    logic last_slot;
    logic done;
    logic rel;
    sample_t q0 [NUM_INPUTS];
    assign accept = bus.in_valid && bus.in_ready;
    assign last_slot = count == CW'(NUM_INPUTS - 1);
    assign done = accept && last_slot;
    assign rel = state == HOLDING && bus.output_ready;
    assign bus.inputs_ready = present;
    assign bus.frame_error = error;
`ifdef INPUT_BUFFER_DOUBLE_BUFFER_EN
    logic fill_sel;
    logic pending;
    logic pend_err;
    sample_t q1 [NUM_INPUTS];
    assign bus.in_ready = !pending;
    input_bank #(.NUM_INPUTS(NUM_INPUTS), .CW(CW)) bank0 (
        .clock(clock), .reset(reset), .we(accept && !fill_sel),
        .idx(count), .din(bus.in_data), .q(q0)
    );
    input_bank #(.NUM_INPUTS(NUM_INPUTS), .CW(CW)) bank1 (
        .clock(clock), .reset(reset), .we(accept && fill_sel),
        .idx(count), .din(bus.in_data), .q(q1)
    );
    // the presented bank is always the one not being filled
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_out
        assign bus.inputs[i] = fill_sel ? q0[i] : q1[i];
    end
`else
    assign bus.in_ready = state == FILLING;
    input_bank #(.NUM_INPUTS(NUM_INPUTS), .CW(CW)) bank0 (
        .clock(clock), .reset(reset), .we(accept),
        .idx(count), .din(bus.in_data), .q(q0)
    );
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_out
        assign bus.inputs[i] = q0[i];
    end
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILLING;
            count <= '0;
            present <= 1'b0;
            error <= 1'b0;
`ifdef INPUT_BUFFER_DOUBLE_BUFFER_EN
            fill_sel <= 1'b0;
            pending <= 1'b0;
            pend_err <= 1'b0;
`endif
        end else begin
            present <= 1'b0;
            state <= state == PRESENTING ? HOLDING : rel ? FILLING : state;
            if (accept) count <= (last_slot || bus.in_last) ? '0 : count + CW'(1);
            // early in_last drops the partial frame; a full frame without in_last is still presented
            error <= accept && !last_slot && bus.in_last;
`ifdef INPUT_BUFFER_DOUBLE_BUFFER_EN
            if (done && (state == FILLING || rel)) begin
                fill_sel <= !fill_sel;
                state <= PRESENTING;
                present <= 1'b1;
                error <= !bus.in_last;
            end else if (done) begin
                pending <= 1'b1;
                pend_err <= !bus.in_last;
            end else if (pending && rel) begin
                fill_sel <= !fill_sel;
                state <= PRESENTING;
                present <= 1'b1;
                error <= pend_err;
                pending <= 1'b0;
            end
`else
            if (done) begin
                state <= PRESENTING;
                present <= 1'b1;
                error <= !bus.in_last;
            end
`endif
        end
    end
endmodule

// File: tb/tb_input_buffer.sv
// tb_input_buffer: table vectors, directed frame sequences and a random run against a frame-level model
module tb_input_buffer;
    import input_buffer_pkg::*;
    localparam int N = 16;
    localparam int ONE = 1 << FRACTION_WIDTH;
`ifdef INPUT_BUFFER_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    input_buffer_if #(.NUM_INPUTS(N)) bus ();
    input_buffer #(.NUM_INPUTS(N)) dut (.clock(clock), .reset(reset), .bus(bus));
    int n_chk = 0;
    int n_fail = 0;
    typedef struct {
        bit valid;
        bit last;
        bit oready;
        int data;
        bit exp_inr;
        bit exp_ir;
        bit exp_fe;
        bit chk;
    } vec_t;
    vec_t vecs[$];
    sample_t frame_a [N];
    sample_t frame_b [N];
    sample_t zeros [N];
    // frame-level model: frame being collected, frame shown downstream, one completed frame waiting
    sample_t shown [N];
    sample_t waitf [N];
    sample_t cur[$];
    bit held, just, waiting, werr, m_ir, m_fe;

    task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_frame(input string name, input sample_t exp [N]);
        for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", name, i), bus.inputs[i], exp[i]);
    endtask

    task automatic drive(input bit v, input bit l, input bit o, input sample_t d);
        bus.in_valid = v;
        bus.in_last = l;
        bus.output_ready = o;
        bus.in_data = d;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mkramp(input int base, output sample_t r [N]);
        for (int i = 0; i < N; i++) r[i] = sample_t'((base + i) * ONE);
    endtask

    function automatic vec_t mk(bit v, bit l, bit o, int d, bit inr, bit ir, bit fe, bit ck);
        vec_t x;
        x = '{v, l, o, d, inr, ir, fe, ck};
        return x;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, '0);
        tick();
        tick();
        chk("reset inputs_ready", bus.inputs_ready, 0);
        chk("reset frame_error", bus.frame_error, 0);
        chk_frame("reset inputs", zeros);
        reset = 1'b0;
        chk("reset in_ready", bus.in_ready, 1);
    endtask

    // streams N back-to-back ramp samples starting at base; checks presentation one cycle after the last accept
    task automatic stream(input int base, input bit lastflag, input bit exp_present, input sample_t exp [N]);
        for (int i = 0; i < N; i++) begin
            drive(1, lastflag && i == N - 1, 0, sample_t'((base + i) * ONE));
            chk("stream in_ready", bus.in_ready, 1);
            tick();
            if (i < N - 1) chk("stream early inputs_ready", bus.inputs_ready, 0);
        end
        drive(0, 0, 0, '0);
        chk("stream inputs_ready", bus.inputs_ready, exp_present);
        chk("stream frame_error", bus.frame_error, exp_present && !lastflag);
        chk_frame("stream inputs", exp);
    endtask

    task automatic release_frame();
        drive(0, 0, 1, '0);
        tick();
        tick();
        drive(0, 0, 0, '0);
        chk("release in_ready", bus.in_ready, 1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) shown[i] = '0;
        cur.delete();
        held = 0;
        just = 0;
        waiting = 0;
        werr = 0;
    endtask

    function automatic bit m_inr();
        return DB ? !waiting : !held;
    endfunction

    task automatic model_step(input bit v, input bit l, input bit o, input sample_t d);
        bit acc;
        acc = v && m_inr();
        m_ir = 0;
        m_fe = 0;
        if (held && !just && o) held = 0;
        if (acc) begin
            if (!DB) shown[cur.size()] = d;
            cur.push_back(d);
            if (cur.size() == N) begin
                if (!held) begin
                    for (int i = 0; i < N; i++) shown[i] = cur[i];
                    held = 1;
                    m_ir = 1;
                    m_fe = !l;
                end else begin
                    for (int i = 0; i < N; i++) waitf[i] = cur[i];
                    waiting = 1;
                    werr = !l;
                end
                cur.delete();
            end else if (l) begin
                cur.delete();
                m_fe = 1;
            end
        end else if (waiting && !held) begin
            shown = waitf;
            held = 1;
            m_ir = 1;
            m_fe = werr;
            waiting = 0;
        end
        just = m_ir;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit v, l, o;
        sample_t d;
        for (int i = 0; i < N; i++) zeros[i] = '0;
        mkramp(1, frame_a);
        mkramp(101, frame_b);
        drive(0, 0, 0, '0);
        // table: early in_last, clean frame, output_ready ignored while filling/presenting, hold, release
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, i == 4, 0, (i + 1) * ONE, 1, 0, i == 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < N; i++) vecs.push_back(mk(1, i == N - 1, 1, (i + 1) * ONE, 1, i == N - 1, 0, i == N - 1));
        vecs.push_back(mk(0, 0, 1, 0, DB, 0, 0, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, DB, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, DB, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 7 * ONE, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        do_reset();
        foreach (vecs[k]) begin
            drive(vecs[k].valid, vecs[k].last, vecs[k].oready, sample_t'(vecs[k].data));
            chk($sformatf("vec%0d in_ready", k), bus.in_ready, vecs[k].exp_inr);
            tick();
            chk($sformatf("vec%0d inputs_ready", k), bus.inputs_ready, vecs[k].exp_ir);
            chk($sformatf("vec%0d frame_error", k), bus.frame_error, vecs[k].exp_fe);
            if (vecs[k].chk) chk_frame($sformatf("vec%0d inputs", k), frame_a);
        end
        // clean frame, then a full frame without in_last
        do_reset();
        stream(1, 1, 1, frame_a);
        release_frame();
        stream(1, 0, 1, frame_a);
        release_frame();
        do_reset();
        stream(1, 1, 1, frame_a);
`ifdef INPUT_BUFFER_DOUBLE_BUFFER_EN
        stream(101, 1, 0, frame_a);
        chk("db fill bank full in_ready", bus.in_ready, 0);
        drive(0, 0, 1, '0);
        tick();
        drive(0, 0, 0, '0);
        chk("db swap inputs_ready", bus.inputs_ready, 1);
        chk("db swap frame_error", bus.frame_error, 0);
        chk_frame("db swap inputs", frame_b);
        release_frame();
`else
        for (int c = 0; c < 20; c++) begin
            drive(1, 0, 0, sample_t'(c * 3 - 30));
            chk("hold in_ready", bus.in_ready, 0);
            tick();
            chk("hold inputs_ready", bus.inputs_ready, 0);
            chk_frame("hold inputs", frame_a);
        end
        drive(0, 0, 1, '0);
        tick();
        drive(0, 0, 0, '0);
        chk("hold release in_ready", bus.in_ready, 1);
        chk("hold release inputs_ready", bus.inputs_ready, 0);
`endif
        // reset after 8 samples, then a clean frame with no residue
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, sample_t'(-(i + 50) * ONE));
            tick();
        end
        reset = 1'b1;
        drive(0, 0, 0, '0);
        tick();
        chk("midreset inputs_ready", bus.inputs_ready, 0);
        chk("midreset frame_error", bus.frame_error, 0);
        chk_frame("midreset inputs", zeros);
        reset = 1'b0;
        chk("midreset in_ready", bus.in_ready, 1);
        stream(1, 1, 1, frame_a);
        release_frame();
        // random traffic against the frame-level model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            v = $urandom_range(0, 3) != 0;
            l = $urandom_range(0, 19) == 0;
            o = $urandom_range(0, 3) == 0;
            d = sample_t'($urandom);
            drive(v, l, o, d);
            chk("rnd in_ready", bus.in_ready, m_inr());
            model_step(v, l, o, d);
            tick();
            chk("rnd inputs_ready", bus.inputs_ready, m_ir);
            chk("rnd frame_error", bus.frame_error, m_fe);
            chk_frame("rnd inputs", shown);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
